// File: rtl/riscv_lsu_pkg.sv
// Shared constants and types for the RISC-V load/store unit.
package riscv_lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NBYTES = XLEN / 8;

    // Major opcodes served by this unit
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } lsu_state_e;

    // Request attributes kept for the duration of an access
    typedef struct packed {
        logic       store;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } lsu_req_t;

endpackage

// File: rtl/riscv_lsu_if.sv
// CPU-side request/response bus and word-addressed memory port.
interface riscv_lsu_if;
    import riscv_lsu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_err;
    logic [XLEN-1:0] resp_rdata;

    // CPU execute stage side
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    // Load/store unit side
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

interface riscv_lsu_mem_if;
    import riscv_lsu_pkg::*;

    logic [XLEN-1:0]   mem_addr;
    logic              mem_rstrb;
    logic [NBYTES-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ready;

    // Load/store unit side
    modport master (
        output mem_addr, mem_rstrb, mem_wmask, mem_wdata,
        input  mem_rdata, mem_ready
    );

    // Memory side
    modport slave (
        input  mem_addr, mem_rstrb, mem_wmask, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: store mask/data, load extraction, legality and alignment.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic              store,
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [NBYTES-1:0] wmask_c,
    output logic [XLEN-1:0]   wdata_c,
    output logic [XLEN-1:0]   rdata_c,
    output logic              illegal_c,
    output logic              misaligned_c
);

    logic [XLEN-1:0] shifted;

    // Decode access size and steer lanes in both directions
    always_comb begin
        wmask_c      = '0;
        wdata_c      = '0;
        rdata_c      = '0;
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        shifted      = rdata >> {addr_lo, 3'b000};

        case ({store, funct3})
            {1'b1, F3_SB}: begin
                wmask_c = 4'b0001 << addr_lo;
                wdata_c = {4{wdata[7:0]}};
            end
            {1'b1, F3_SH}: begin
                wmask_c      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_c      = {2{wdata[15:0]}};
                misaligned_c = addr_lo[0];
            end
            {1'b1, F3_SW}: begin
                wmask_c      = 4'b1111;
                wdata_c      = wdata;
                misaligned_c = |addr_lo;
            end
            {1'b0, F3_LB}:  rdata_c = {{24{shifted[7]}}, shifted[7:0]};
            {1'b0, F3_LBU}: rdata_c = {24'h0, shifted[7:0]};
            {1'b0, F3_LH}: begin
                rdata_c      = {{16{shifted[15]}}, shifted[15:0]};
                misaligned_c = addr_lo[0];
            end
            {1'b0, F3_LHU}: begin
                rdata_c      = {16'h0, shifted[15:0]};
                misaligned_c = addr_lo[0];
            end
            {1'b0, F3_LW}: begin
                rdata_c      = shifted;
                misaligned_c = |addr_lo;
            end
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: accepts one access from execute, drives memory, returns result.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    riscv_lsu_if.slave      cpu,
    riscv_lsu_mem_if.master mem
);

    // Counter must hold TIMEOUT; keep one bit when timeouts are disabled
    localparam int unsigned     CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

    lsu_state_e        state;
    lsu_req_t          req_q;
    logic [CNT_W-1:0]  cnt;

    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [XLEN-1:0]   resp_rdata_q;
    logic [XLEN-1:0]   mem_addr_q;
    logic              mem_rstrb_q;
    logic [NBYTES-1:0] mem_wmask_q;
    logic [XLEN-1:0]   mem_wdata_q;

    logic              idle_c;
    logic              accept_c;
    logic              timeout_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              al_store_c;
    logic [2:0]        al_funct3_c;
    logic [1:0]        al_addr_lo_c;
    logic [NBYTES-1:0] al_wmask_c;
    logic [XLEN-1:0]   al_wdata_c;
    logic [XLEN-1:0]   al_rdata_c;
    logic              al_illegal_c;
    logic              al_misaligned_c;

    // Lane logic sees the live request in IDLE and the held request afterwards
    assign idle_c       = (state == ST_IDLE);
    assign al_store_c   = idle_c ? cpu.req_store      : req_q.store;
    assign al_funct3_c  = idle_c ? cpu.req_funct3     : req_q.funct3;
    assign al_addr_lo_c = idle_c ? cpu.req_addr[1:0]  : req_q.addr_lo;

    assign accept_c  = idle_c && req_ready_q && cpu.req_valid;
    assign cnt_inc_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign timeout_c = (TIMEOUT != 0) && (cnt_inc_c == TMO);

    riscv_lsu_align u_align (
        .store        (al_store_c),
        .funct3       (al_funct3_c),
        .addr_lo      (al_addr_lo_c),
        .wdata        (cpu.req_wdata),
        .rdata        (mem.mem_rdata),
        .wmask_c      (al_wmask_c),
        .wdata_c      (al_wdata_c),
        .rdata_c      (al_rdata_c),
        .illegal_c    (al_illegal_c),
        .misaligned_c (al_misaligned_c)
    );

    // Access FSM with request latches, timeout counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            req_q        <= '0;
            cnt          <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_rstrb_q  <= 1'b0;
            mem_wmask_q  <= '0;
            mem_wdata_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;

            case (state)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept_c) begin
                        req_ready_q   <= 1'b0;
                        req_q.store   <= cpu.req_store;
                        req_q.funct3  <= cpu.req_funct3;
                        req_q.addr_lo <= cpu.req_addr[1:0];
                        mem_addr_q    <= {cpu.req_addr[31:2], 2'b00};
                        if (al_illegal_c || al_misaligned_c) begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state       <= ST_ISSUE;
                            cnt         <= '0;
                            mem_rstrb_q <= !cpu.req_store;
                            mem_wmask_q <= al_wmask_c;
                            mem_wdata_q <= al_wdata_c;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (mem.mem_ready) begin
                        state        <= ST_RESP;
                        mem_rstrb_q  <= 1'b0;
                        mem_wmask_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= req_q.store ? '0 : al_rdata_c;
                    end else if (timeout_c) begin
                        state        <= ST_RESP;
                        mem_rstrb_q  <= 1'b0;
                        mem_wmask_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end

                ST_RESP: begin
                    state       <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end

                default: begin
                    state       <= ST_IDLE;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu.req_ready  = req_ready_q;
    assign cpu.resp_valid = resp_valid_q;
    assign cpu.resp_err   = resp_err_q;
    assign cpu.resp_rdata = resp_rdata_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_rstrb  = mem_rstrb_q;
    assign mem.mem_wmask  = mem_wmask_q;
    assign mem.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized bench for riscv_lsu against a byte-level reference model.
module tb_riscv_lsu;

    localparam int unsigned TMO = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    riscv_lsu_if     cpu_bus ();
    riscv_lsu_mem_if mem_bus ();

    riscv_lsu #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu_bus),
        .mem   (mem_bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: behaviour derived from access size in bytes and byte offset
    function automatic void model(input logic st, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata,
                                  output logic err, output logic [3:0] wmask,
                                  output logic [31:0] wlanes, output logic [31:0] ld);
        int  nb;
        int  off;
        bit  legal;
        nb    = 1 << f3[1:0];
        off   = int'(addr % 32'd4);
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err    = !legal || ((off % nb) != 0);
        wmask  = '0;
        wlanes = '0;
        ld     = '0;
        if (err) return;
        if (st) begin
            wmask = 4'(((1 << nb) - 1) << off);
            for (int b = 0; b < 4; b++) wlanes[8*b +: 8] = wdata[8*(b % nb) +: 8];
        end else begin
            for (int i = 0; i < nb; i++) ld[8*i +: 8] = rdata[8*(off + i) +: 8];
            if (!f3[2] && nb < 4 && ld[8*nb - 1])
                for (int i = nb; i < 4; i++) ld[8*i +: 8] = 8'hFF;
        end
    endfunction

    task automatic drive_junk(input bit en);
        cpu_bus.req_valid = en;
        if (en) begin
            cpu_bus.req_store  = 1'($urandom_range(1));
            cpu_bus.req_funct3 = 3'($urandom_range(7));
            cpu_bus.req_addr   = $urandom;
            cpu_bus.req_wdata  = $urandom;
        end
    endtask

    // One access; lat = ISSUE cycle (1-based) carrying mem_ready, >TMO means never
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int lat, input bit junk);
        logic        err;
        logic [3:0]  wm;
        logic [31:0] wl;
        logic [31:0] ld;
        logic        tmo_err;
        int          k;
        bit          done;
        model(st, f3, addr, wdata, rdata, err, wm, wl, ld);

        k = 0;
        while (cpu_bus.req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_before_accept", 32'(cpu_bus.req_ready), 32'd1);

        cpu_bus.req_valid  = 1'b1;
        cpu_bus.req_store  = st;
        cpu_bus.req_funct3 = f3;
        cpu_bus.req_addr   = addr;
        cpu_bus.req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        drive_junk(junk);

        if (err) begin
            chk("err_resp_valid", 32'(cpu_bus.resp_valid), 32'd1);
            chk("err_resp_err",   32'(cpu_bus.resp_err),   32'd1);
            chk("err_resp_rdata", cpu_bus.resp_rdata,      32'd0);
            chk("err_no_rstrb",   32'(mem_bus.mem_rstrb),  32'd0);
            chk("err_no_wmask",   32'(mem_bus.mem_wmask),  32'd0);
        end else begin
            done = 1'b0;
            for (int c = 1; c <= int'(TMO) && !done; c++) begin
                chk("issue_resp_valid", 32'(cpu_bus.resp_valid), 32'd0);
                chk("issue_req_ready",  32'(cpu_bus.req_ready),  32'd0);
                chk("issue_rstrb",      32'(mem_bus.mem_rstrb),  32'(!st));
                chk("issue_wmask",      32'(mem_bus.mem_wmask),  32'(wm));
                chk("issue_addr",       mem_bus.mem_addr,        addr & 32'hFFFF_FFFC);
                if (st) chk("issue_wdata", mem_bus.mem_wdata, wl);
                mem_bus.mem_ready = (c == lat);
                mem_bus.mem_rdata = (c == lat) ? rdata : $urandom;
                @(negedge clk);
                mem_bus.mem_ready = 1'b0;
                drive_junk(junk);
                if (c == lat) done = 1'b1;
            end
            tmo_err = (lat > int'(TMO));
            chk("resp_valid", 32'(cpu_bus.resp_valid), 32'd1);
            chk("resp_err",   32'(cpu_bus.resp_err),   32'(tmo_err));
            chk("resp_rdata", cpu_bus.resp_rdata,      (tmo_err || st) ? 32'd0 : ld);
            chk("resp_rstrb_low", 32'(mem_bus.mem_rstrb), 32'd0);
            chk("resp_wmask_low", 32'(mem_bus.mem_wmask), 32'd0);
        end
        cpu_bus.req_valid = 1'b0;
        @(negedge clk);
        chk("post_resp_valid", 32'(cpu_bus.resp_valid), 32'd0);
        chk("post_req_ready",  32'(cpu_bus.req_ready),  32'd1);
    endtask

    // Reset in the middle of an ISSUE phase
    task automatic reset_mid_issue();
        chk("rst_pre_ready", 32'(cpu_bus.req_ready), 32'd1);
        cpu_bus.req_valid  = 1'b1;
        cpu_bus.req_store  = 1'b0;
        cpu_bus.req_funct3 = 3'b010;
        cpu_bus.req_addr   = 32'h0000_0200;
        @(posedge clk);
        @(negedge clk);
        cpu_bus.req_valid = 1'b0;
        chk("rst_in_issue_rstrb", 32'(mem_bus.mem_rstrb), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rstrb_low",  32'(mem_bus.mem_rstrb),  32'd0);
        chk("rst_wmask_low",  32'(mem_bus.mem_wmask),  32'd0);
        chk("rst_resp_valid", 32'(cpu_bus.resp_valid), 32'd0);
        chk("rst_req_ready",  32'(cpu_bus.req_ready),  32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_exit_ready",      32'(cpu_bus.req_ready),  32'd1);
        chk("rst_exit_resp_valid", 32'(cpu_bus.resp_valid), 32'd0);
        @(negedge clk);
        chk("rst_idle_resp_valid", 32'(cpu_bus.resp_valid), 32'd0);
        chk("rst_idle_rstrb",      32'(mem_bus.mem_rstrb),  32'd0);
    endtask

    initial begin
        reset              = 1'b1;
        cpu_bus.req_valid  = 1'b0;
        cpu_bus.req_store  = 1'b0;
        cpu_bus.req_funct3 = '0;
        cpu_bus.req_addr   = '0;
        cpu_bus.req_wdata  = '0;
        mem_bus.mem_rdata  = '0;
        mem_bus.mem_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready",  32'(cpu_bus.req_ready),  32'd0);
        chk("reset_resp_valid", 32'(cpu_bus.resp_valid), 32'd0);
        chk("reset_resp_rdata", cpu_bus.resp_rdata,      32'd0);
        chk("reset_rstrb",      32'(mem_bus.mem_rstrb),  32'd0);
        chk("reset_wmask",      32'(mem_bus.mem_wmask),  32'd0);
        chk("reset_mem_addr",   mem_bus.mem_addr,        32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_exit_ready", 32'(cpu_bus.req_ready), 32'd1);

        // Directed cases
        run_txn(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         1, 1'b0);
        run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_1234, 1, 1'b0);
        run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF_1234, 1, 1'b0);
        run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'h8001_0000, 2, 1'b0);
        run_txn(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0,         1, 1'b0);
        run_txn(1'b0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,         1, 1'b0);
        run_txn(1'b1, 3'b001, 32'h0000_0103, 32'h1234_5678, 32'h0,         1, 1'b0);
        run_txn(1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         1, 1'b0);
        run_txn(1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, TMO + 1, 1'b0);
        run_txn(1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, TMO, 1'b0);
        run_txn(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,         3, 1'b1);
        reset_mid_issue();

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            run_txn(1'($urandom_range(1)), 3'($urandom_range(7)), $urandom, $urandom,
                    $urandom, int'($urandom_range(1, TMO + 2)), 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
